hba_bus_arbiter: RTL and testbench
==================================

# hba_bus_arbiter

Round-robin arbiter that shares the single HBA slave bus (`DBUS_WIDTH` data, `PERIPH_ADDR_WIDTH`+`REG_ADDR_WIDTH` address) between up to four bus masters, e.g. `serial_fpga` and an autonomous on-chip sequencer. It sits inside `hba_system` between the master ports and the peripheral slots. It grants exclusive ownership per request and multiplexes the owner's address, data, rnw and select onto the shared bus. It enforces a dead cycle on every handover.

## Interface
- `NUM_MASTERS`, 2, number of masters (legal 2..4)
- `DBUS_WIDTH`, 8, data bus width
- `PERIPH_ADDR_WIDTH`, 4, peripheral select field width
- `REG_ADDR_WIDTH`, 8, register field width; `AW` = `PERIPH_ADDR_WIDTH`+`REG_ADDR_WIDTH`
- `TIMEOUT_CYCLES`, 255, select-without-xferack limit (8-bit, 1..255)

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high
- `mreq` in `NUM_MASTERS`: per-master bus request
- `mgrant` out `NUM_MASTERS`: registered one-hot grant
- `m_abus` in `NUM_MASTERS*AW`: master addresses, master i at `[i*AW +: AW]`
- `m_dbus` in `NUM_MASTERS*DBUS_WIDTH`: master write data
- `m_rnw` in `NUM_MASTERS`: 1 = read
- `m_select` in `NUM_MASTERS`: transfer strobe
- `hba_abus` out `AW`, `hba_dbus` out `DBUS_WIDTH`, `hba_rnw` out 1, `hba_select` out 1: shared bus
- `hba_xferack` in 1: slave transfer acknowledge
- `arb_owner` out 2: index of last/current owner
- `arb_timeout` out 1: one-cycle revoke pulse

## Operation
- States: IDLE, BUSY, PARK.
- IDLE
  - If any `mreq` is set, pick the first requester searching from `(last_owner+1) mod NUM_MASTERS` upward with wrap.
  - Register `owner` and set `mgrant[owner]`. Go to BUSY.
- BUSY
  - Bus outputs = owner's inputs, combinationally muxed from registered `owner`.
  - Release when `mreq[owner]==0` AND `m_select[owner]==0`: clear `mgrant`, set `last_owner=owner`, go to PARK.
  - A request dropped while select is high keeps the grant until select falls.
- PARK
  - One dead cycle with no grant and bus outputs forced to 0. Then go to IDLE.
- Bus outputs whenever no grant is held: `hba_select=0`, `hba_abus=0`, `hba_dbus=0`, `hba_rnw=0`.
- `mreq` from non-owners is ignored during BUSY and PARK. No preemption occurs except by timeout.
- Reset values: `mgrant=0`, `arb_owner=NUM_MASTERS-1`, all `hba_*` outputs 0, `arb_timeout=0`, state IDLE. With this `arb_owner` value, master 0 wins first after reset.
- Reset mid-transfer: grant and select drop in the cycle after reset is sampled. Any in-flight transfer is abandoned.
- Out-of-range owner indices are unreachable. For `NUM_MASTERS` < 4, unused search positions are skipped.

## Timing
- Grant latency: `mreq` sampled high in IDLE at edge t gives `mgrant` high after edge t (visible in cycle t+1).
- Bus path: master inputs to `hba_*` is zero-latency combinational through the owner mux.
- Handover: release condition true at edge t gives grant low at t+1 (PARK), IDLE at t+2, and the next grant visible at t+3.
  - Minimum gap between two owners is 2 cycles with no grant.
- Back-to-back requests from the same master also take the PARK/IDLE path. No grant is held across a release.

## Configuration
- Macro `HBA_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears when `hba_select==0` or `hba_xferack==1`, and increments otherwise while in BUSY.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter drops `mgrant` and forces `hba_select` to 0 on the next cycle.
  - It pulses `arb_timeout` for 1 cycle, sets `last_owner=owner` and goes to PARK.
  - The master must drop and re-raise `mreq` to be re-granted.
- Undefined: counter absent, `arb_timeout` tied 0, grants held indefinitely.

## Test plan
- Reset released, `mreq=2'b01` at cycle 5 -> `mgrant=2'b01` at cycle 6; `m_abus[0]=12'h1_05`, `m_select[0]=1` -> `hba_abus=12'h105`, `hba_select=1` same cycle.
- `mreq=2'b11` from IDLE after reset -> master 0 granted. When master 0 releases at cycle t, `mgrant=2'b10` at t+3 and `arb_owner=1`.
- Master 0 drops `mreq` while `m_select[0]=1` for 4 more cycles -> grant held until the cycle after select falls, then the 2-cycle gap.
- Both masters request continuously, each releasing after one transfer -> grants alternate 0,1,0,1. No master is granted twice in a row.
- Timeout (macro defined, `TIMEOUT_CYCLES=10`): owner holds select and `hba_xferack` stays 0 -> `arb_timeout` pulses once at the 10th held cycle, then `mgrant=0` and `hba_select=0`. Undefined: grant persists after 300 cycles.
- Reset asserted mid-transfer -> `mgrant=0`, `hba_select=0` next cycle. After release, master 0 wins the first arbitration.

Source files
------------

// File: rtl/hba_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hba_bus_arbiter                                                 |
// | Purpose  : Round-robin owner arbiter and mux for the shared HBA slave bus; |
// |            optional select-stall timeout enabled by HBA_ARB_TIMEOUT_EN.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hba_bus_arbiter #(
  parameter int NUM_MASTERS       = 2,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_MASTERS-1:0]                                 mreq,
  output logic [NUM_MASTERS-1:0]                                 mgrant,
  input  logic [NUM_MASTERS*(PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH)-1:0] m_abus,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0]                      m_dbus,
  input  logic [NUM_MASTERS-1:0]                                 m_rnw,
  input  logic [NUM_MASTERS-1:0]                                 m_select,
  output logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0]            hba_abus,
  output logic [DBUS_WIDTH-1:0]                                  hba_dbus,
  output logic                                                   hba_rnw,
  output logic                                                   hba_select,
  input  logic                                                   hba_xferack,
  output logic [1:0]                                             arb_owner,
  output logic                                                   arb_timeout
);

  localparam int c_AW = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_PARK = 2'd2
  } state_t;

  state_t                 r_state, w_state_n;
  logic [1:0]             r_owner, w_owner_n;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_n;
  logic                   w_timeout_n;
  logic [NUM_MASTERS-1:0] w_req;
  logic [1:0]             w_pick;
  logic [NUM_MASTERS-1:0] w_pick_oh;
  logic                   w_found;
  logic                   w_own_req, w_own_sel, w_own_rnw;
  logic [c_AW-1:0]        w_own_abus;
  logic [DBUS_WIDTH-1:0]  w_own_dbus;
  logic                   w_hit;
  logic                   w_unused;

  // Owner mux; compares rather than indexes so the 2-bit owner never over-reaches.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_sel  = 1'b0;
    w_own_rnw  = 1'b0;
    w_own_abus = '0;
    w_own_dbus = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_owner == 2'(i)) begin
        w_own_req  = mreq[i];
        w_own_sel  = m_select[i];
        w_own_rnw  = m_rnw[i];
        w_own_abus = m_abus[i*c_AW +: c_AW];
        w_own_dbus = m_dbus[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
  end

  // First requester after the previous owner, wrapping within NUM_MASTERS.
  always_comb begin
    w_found   = 1'b0;
    w_pick    = r_owner;
    w_pick_oh = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(r_owner) + k) % NUM_MASTERS;
      if (!w_found && w_req[idx]) begin
        w_found        = 1'b1;
        w_pick         = 2'(idx);
        w_pick_oh[idx] = 1'b1;
      end
    end
  end

  assign hba_select = |r_grant & w_own_sel;
  assign hba_abus   = (|r_grant) ? w_own_abus : '0;
  assign hba_dbus   = (|r_grant) ? w_own_dbus : '0;
  assign hba_rnw    = |r_grant & w_own_rnw;
  assign mgrant     = r_grant;
  assign arb_owner  = r_owner;

`ifdef HBA_ARB_TIMEOUT_EN
  logic [7:0]             r_tcnt;
  logic                   r_timeout;
  logic [NUM_MASTERS-1:0] r_blocked;
  logic                   w_held;

  assign w_held      = hba_select & ~hba_xferack;
  assign w_hit       = (r_state == S_BUSY) && w_held && (r_tcnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_req       = mreq & ~r_blocked;
  assign arb_timeout = r_timeout;
  assign w_unused    = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
      r_blocked <= '0;
    end else begin
      r_timeout <= w_timeout_n;
      if (r_state == S_BUSY && w_held && !w_hit) r_tcnt <= r_tcnt + 8'd1;
      else                                       r_tcnt <= '0;
      // A revoked master stays locked out until it drops its request once.
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!mreq[i])                            r_blocked[i] <= 1'b0;
        else if (w_hit && r_owner == 2'(i))      r_blocked[i] <= 1'b1;
      end
    end
  end
`else
  assign w_hit       = 1'b0;
  assign w_req       = mreq;
  assign arb_timeout = 1'b0;
  assign w_unused    = hba_xferack ^ (TIMEOUT_CYCLES == 0) ^ w_timeout_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= 2'(NUM_MASTERS - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_grant <= w_grant_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_grant_n   = r_grant;
    w_timeout_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_n = w_pick;
          w_grant_n = w_pick_oh;
          w_state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_own_req && !w_own_sel) begin
          w_grant_n = '0;
          w_state_n = S_PARK;
        end else if (w_hit) begin
          w_grant_n   = '0;
          w_timeout_n = 1'b1;
          w_state_n   = S_PARK;
        end
      end
      S_PARK: begin
        w_grant_n = '0;
        w_state_n = S_IDLE;
      end
      default: begin
        w_grant_n = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hba_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hba_bus_arbiter                                              |
// | Purpose  : Directed self-checking bench for hba_bus_arbiter (2 masters).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hba_bus_arbiter;

  localparam int c_N  = 2;
  localparam int c_AW = 12;
  localparam int c_DW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [c_N-1:0]       mreq;
  logic [c_N-1:0]       mgrant;
  logic [c_N*c_AW-1:0]  m_abus;
  logic [c_N*c_DW-1:0]  m_dbus;
  logic [c_N-1:0]       m_rnw;
  logic [c_N-1:0]       m_select;
  logic [c_AW-1:0]      hba_abus;
  logic [c_DW-1:0]      hba_dbus;
  logic                 hba_rnw;
  logic                 hba_select;
  logic                 hba_xferack;
  logic [1:0]           arb_owner;
  logic                 arb_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int o;

  always #5 clk = ~clk;

  hba_bus_arbiter #(
    .NUM_MASTERS      (c_N),
    .DBUS_WIDTH       (c_DW),
    .PERIPH_ADDR_WIDTH(4),
    .REG_ADDR_WIDTH   (8),
    .TIMEOUT_CYCLES   (10)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .mreq       (mreq),
    .mgrant     (mgrant),
    .m_abus     (m_abus),
    .m_dbus     (m_dbus),
    .m_rnw      (m_rnw),
    .m_select   (m_select),
    .hba_abus   (hba_abus),
    .hba_dbus   (hba_dbus),
    .hba_rnw    (hba_rnw),
    .hba_select (hba_select),
    .hba_xferack(hba_xferack),
    .arb_owner  (arb_owner),
    .arb_timeout(arb_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mreq = '0; m_abus = '0; m_dbus = '0;
    m_rnw = '0; m_select = '0; hba_xferack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_grant",   32'(mgrant),      32'h0);
    check("rst_owner",   32'(arb_owner),   32'h1);
    check("rst_select",  32'(hba_select),  32'h0);
    check("rst_abus",    32'(hba_abus),    32'h0);
    check("rst_timeout", 32'(arb_timeout), 32'h0);
    tick(); tick(); tick();

    // Master 0 request and zero-latency bus path.
    mreq = 2'b01; m_abus[11:0] = 12'h105; m_dbus[7:0] = 8'hA5; m_select = 2'b01;
    #1;
    check("pregrant_sel",  32'(hba_select), 32'h0);
    check("pregrant_abus", 32'(hba_abus),   32'h0);
    tick();
    check("grant0",     32'(mgrant),     32'h1);
    check("owner0",     32'(arb_owner),  32'h0);
    check("bus_abus0",  32'(hba_abus),   32'h105);
    check("bus_dbus0",  32'(hba_dbus),   32'hA5);
    check("bus_sel0",   32'(hba_select), 32'h1);
    check("bus_rnw0",   32'(hba_rnw),    32'h0);

    // Request dropped while select held: grant persists.
    mreq = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_grant", 32'(mgrant), 32'h1);
    end

    // Release, then two dead cycles before master 1.
    m_select = 2'b00; mreq = 2'b10;
    m_abus[23:12] = 12'h2AB; m_dbus[15:8] = 8'h3C; m_rnw = 2'b10;
    tick();
    check("park_grant", 32'(mgrant),   32'h0);
    check("park_abus",  32'(hba_abus), 32'h0);
    check("park_rnw",   32'(hba_rnw),  32'h0);
    tick();
    check("idle_grant", 32'(mgrant), 32'h0);
    tick();
    check("grant1",  32'(mgrant),    32'h2);
    check("owner1",  32'(arb_owner), 32'h1);
    m_select = 2'b10;
    #1;
    check("bus_abus1", 32'(hba_abus),   32'h2AB);
    check("bus_dbus1", 32'(hba_dbus),   32'h3C);
    check("bus_rnw1",  32'(hba_rnw),    32'h1);
    check("bus_sel1",  32'(hba_select), 32'h1);

    // Non-owner request ignored while busy.
    mreq = 2'b11;
    tick();
    check("no_preempt", 32'(mgrant), 32'h2);

    // Alternation with both masters requesting.
    o = 1;
    for (int r = 0; r < 4; r++) begin
      mreq[o] = 1'b0; m_select = 2'b00;
      tick();
      check("alt_park", 32'(mgrant), 32'h0);
      mreq = 2'b11;
      tick();
      check("alt_idle", 32'(mgrant), 32'h0);
      tick();
      o = 1 - o;
      check("alt_grant", 32'(mgrant), 32'(1 << o));
    end

    // Master 1 owns; holds select with no acknowledge.
    mreq = 2'b10; m_select = 2'b10; hba_xferack = 1'b0;
`ifdef HBA_ARB_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      tick();
      check("to_hold", 32'(mgrant),      32'h2);
      check("to_nopl", 32'(arb_timeout), 32'h0);
    end
    tick();
    check("to_pulse", 32'(arb_timeout), 32'h1);
    check("to_grant", 32'(mgrant),      32'h0);
    check("to_sel",   32'(hba_select),  32'h0);
    tick();
    check("to_pulse_end", 32'(arb_timeout), 32'h0);
    tick(); tick();
    check("to_blocked", 32'(mgrant), 32'h0);
    mreq = 2'b00;
    tick();
    mreq = 2'b10;
    tick();
    check("to_regrant", 32'(mgrant), 32'h2);
`else
    for (int i = 0; i < 300; i++) tick();
    check("no_to_grant", 32'(mgrant),      32'h2);
    check("no_to_pulse", 32'(arb_timeout), 32'h0);
    check("no_to_sel",   32'(hba_select),  32'h1);
`endif

    // Reset mid-transfer.
    reset = 1'b1; mreq = 2'b11;
    tick();
    check("midrst_grant", 32'(mgrant),     32'h0);
    check("midrst_sel",   32'(hba_select), 32'h0);
    check("midrst_owner", 32'(arb_owner),  32'h1);
    reset = 1'b0;
    tick();
    check("postrst_grant", 32'(mgrant),    32'h1);
    check("postrst_owner", 32'(arb_owner), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
